lb_line_ctrl: RTL
=================

# lb_line_ctrl

Line sequencer for the 8-bit sliding-window line buffer. It accepts a pixel stream over a valid/ready handshake and drives the buffer's single write port. It primes the buffer with FILL words per line, then issues one write per downstream-ready cycle so every buffer output has a consumer. It also tags outputs with start/end-of-line markers, inserts an inter-line gap that clears the buffer, and counts rows to flag frame completion.

## Interface

**Parameters**
- DW, 8, data width
- LINE_LEN, 64, words per line; must be ≥ FILL
- FILL, 8, writes needed before the buffer's first valid output; ≥ 1
- GAP, 2, idle cycles between lines; ≥ 1
- ROWS, 480, lines per frame; ≥ 1

**Ports** (clock and reset first)
- CLK, in, 1: single clock; all state is updated on its rising edge
- RST, in, 1: asynchronous reset, active-high
- en, in, 1: run enable; sampled only at line boundaries
- s_data, in, DW: upstream pixel
- s_valid, in, 1: upstream word available
- s_ready, out, 1: controller accepts s_data this cycle
- lb_wdata, out, DW: to buffer write data; equals s_data
- lb_wen, out, 1: to buffer write enable; equals s_valid & s_ready
- lb_clr, out, 1: one-cycle buffer clear (registered)
- m_valid, out, 1: buffer read data this cycle is a valid window output
- m_ready, in, 1: downstream can take an output this cycle
- m_sol, out, 1: first output of a line (qualifies m_valid)
- m_eol, out, 1: last output of a line (qualifies m_valid)
- col, out, clog2(LINE_LEN): words accepted in the current line
- row, out, clog2(ROWS): current line index
- frame_done, out, 1: registered one-cycle pulse

## Operation

**States:** IDLE, FILL, STREAM, GAP.

- **Reset (asynchronous):** state=IDLE; col=0; row=0; gap_cnt=0; lb_clr=0; frame_done=0.
  - Combinational outputs follow from this: s_ready=0, lb_wen=0, m_valid=0, m_sol=0, m_eol=0.
- **IDLE:** s_ready=0.
  - en=1 → FILL next cycle, with lb_clr=1 in that cycle.
- **FILL:** s_ready=1, because the buffer produces no output yet.
  - Each accepted word increments col.
  - On the write with col==FILL-1:
    - m_valid=1 and m_sol=1 in that same cycle; this write produces the first window.
    - m_ready is ignored here, so the bench must hold m_ready=1 whenever a FILL→STREAM transition is possible.
    - Next state: STREAM. If FILL==LINE_LEN, the line also ends on this write (see end-of-line).
- **STREAM:** s_ready = m_ready.
  - m_valid = lb_wen.
  - m_sol=0.
  - m_eol = lb_wen & (col==LINE_LEN-1).
  - Each write increments col.
- **End-of-line** (write with col==LINE_LEN-1):
  - col → 0.
  - State → GAP; gap_cnt → 0; lb_clr is registered high for the first GAP cycle.
  - If row==ROWS-1: row → 0 and frame_done=1 for the next cycle. Otherwise row increments.
- **GAP:** s_ready=0.
  - gap_cnt counts 0..GAP-1.
  - After GAP cycles: en=1 → FILL; en=0 → IDLE.
- **Outputs per line:** LINE_LEN−FILL+1. m_sol and m_eol coincide when FILL==LINE_LEN.
- **Mid-line en deassertion:** ignored; the line completes.
- **Counter wrap:** no counter wraps except at the named terminal values.

## Timing

- s_ready, lb_wen, lb_wdata, m_valid, m_sol, m_eol: combinational from state and from s_valid/m_ready, with zero latency.
  - No combinational path from s_valid to s_ready.
- lb_clr, frame_done: registered, exactly one cycle wide.
- State, col, row: update on the CLK edge after an accepted write.
- **Throughput:** 1 word/cycle in FILL; in STREAM, limited by min(s_valid, m_ready).
- **Line period** at full rate: LINE_LEN + GAP cycles (plus 1 cycle from IDLE).
- **Async reset during STREAM:**
  - All outputs go low within the same cycle; no lb_wen glitch after RST rises.
  - After release, the controller restarts from IDLE with row=0.
  - The buffer is cleared by the lb_clr issued on the next IDLE→FILL.

## Test plan

Parameters: LINE_LEN=16, FILL=8, GAP=2, ROWS=3.

1. **Reset values:** hold RST for 3 cycles, with s_valid=1 and en=1 → all outputs 0 during reset. After release: lb_clr=1 one cycle after IDLE→FILL, then s_ready=1.
2. **Full-rate line:** s_valid=1 and m_ready=1 continuously →
   - 16 lb_wen pulses and 9 m_valid pulses;
   - m_sol on the 8th write, m_eol on the 16th;
   - 2 gap cycles with lb_clr in the first; row 0→1.
3. **Backpressure:** m_ready toggles 1/0 in STREAM →
   - s_ready and lb_wen are 0 on every m_ready=0 cycle;
   - m_valid count is still 9; col never skips.
4. **Upstream bubbles:** s_valid=0 for 3 cycles inside FILL → col holds; no m_valid until the 8th accepted word.
5. **Frame wrap:** 3 full lines → frame_done pulses once, one cycle after the 48th write; row returns to 0.
6. **Enable and reset mid-operation:**
   - Drop en at col=10 → line completes, GAP runs, then IDLE.
   - Assert RST at col=12 of the next line → immediate IDLE with col=0 and row=0.

Source files
------------

// File: rtl/lb_line_ctrl.sv
// lb_line_ctrl: line sequencer for an 8-bit sliding-window line buffer.
// It primes the buffer with FILL words per line, then writes one word per
// downstream-ready cycle, so every window the buffer produces has a consumer.
// It marks the first and last window of each line, inserts a clearing gap
// between lines, and counts rows to flag the end of a frame.
module lb_line_ctrl #(
  parameter int DW       = 8,
  parameter int LINE_LEN = 64,
  parameter int FILL     = 8,
  parameter int GAP      = 2,
  parameter int ROWS     = 480,
  localparam int CW      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] lb_wdata,
  output logic          lb_wen,
  output logic          lb_clr,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sol,
  output logic          m_eol,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          frame_done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam logic [CW-1:0] COL_LAST  = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] COL_PRIME = CW'(FILL - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  logic [1:0]    state;
  logic [GW-1:0] gap_cnt;
  logic          last_col;
  logic          prime_col;

  assign last_col  = (col == COL_LAST);
  assign prime_col = (col == COL_PRIME);

  // Handshake and window qualifiers: pure decode of state and the two readies.
  // s_ready never looks at s_valid, so no valid->ready loop can form upstream.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_sol   = 1'b0;
    case (state)
      S_FILL:   s_ready = 1'b1;
      S_STREAM: s_ready = m_ready;
      default:  s_ready = 1'b0;
    endcase
    lb_wen = s_valid & s_ready;
    if (state == S_FILL) begin
      m_valid = lb_wen & prime_col;
      m_sol   = lb_wen & prime_col;
    end else if (state == S_STREAM) begin
      m_valid = lb_wen;
    end
    m_eol    = m_valid & last_col;
    lb_wdata = s_data;
  end

  // Line sequencing: state, column/row/gap counters and the registered pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      gap_cnt    <= '0;
      lb_clr     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, regardless of statement order in this block.
      lb_clr     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            state  <= S_FILL;
            lb_clr <= 1'b1;
          end
        end
        S_FILL, S_STREAM: begin
          if (lb_wen) begin
            if (last_col) begin
              col     <= '0;
              state   <= S_GAP;
              gap_cnt <= '0;
              lb_clr  <= 1'b1;
              if (row == ROW_LAST) begin
                row        <= '0;
                frame_done <= 1'b1;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
              if (state == S_FILL && prime_col) state <= S_STREAM;
            end
          end
        end
        default: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= en ? S_FILL : S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
      endcase
    end
  end

endmodule
